fp_add_normalize_stage: RTL



---
 rtl/fpu_add_pkg.sv | 34 +++
 rtl/fp_add_normalize_stage_lzc.sv | 19 +
 rtl/fp_add_normalize_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fpu_add_pkg.sv
// Shared sizes and stage payloads for the floating-point add/sub datapath.
package fpu_add_pkg;

  localparam int unsigned FractionSize = 23;
  localparam int unsigned MantissaSize = FractionSize + 1;
  localparam int unsigned RoundingSize = MantissaSize + 3;
  localparam int unsigned ExponentSize = 8;

  // Adder output carries one extra bit; exponent math carries one extra bit to catch wrap.
  localparam int unsigned SumSize     = RoundingSize + 1;
  localparam int unsigned ExpCalcSize = ExponentSize + 1;
  localparam int unsigned LzcSize     = $clog2(RoundingSize) + 1;

  localparam logic [ExponentSize-1:0] ExponentAllOnes = '1;

  // Register contents after the add sub-stage.
  typedef struct packed {
    logic [SumSize-1:0]      sum;
    logic [ExponentSize-1:0] exponent;
    logic                    eff_sub;
    logic                    sign;
  } s1_payload_t;

  // Register contents after the normalize sub-stage.
  typedef struct packed {
    logic [RoundingSize-1:0] mantissa;
    logic [ExponentSize-1:0] exponent;
    logic                    sign;
    logic                    zero;
    logic                    overflow;
    logic                    underflow;
  } s2_payload_t;

endpackage

// File: rtl/fp_add_normalize_stage_lzc.sv
// Combinational leading-zero counter; an all-zero input reports Width.
module LeadingZeroCounter #(
  parameter int unsigned Width = 27
) (
  input  logic [Width-1:0]       value,
  output logic [$clog2(Width):0] count
);

  localparam int unsigned CountW = $clog2(Width) + 1;

  // Scan upward so the highest set bit determines the count.
  always_comb begin
    count = CountW'(Width);
    for (int unsigned i = 0; i < Width; i++) begin
      if (value[i]) count = CountW'(Width - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_normalize_stage.sv
// Add/normalize stage of the FP add/sub pipeline: mantissa add, then normalize
// and exponent adjust, as two registered sub-stages under valid/ready.
// Optional feature macro: FP_UNDERFLOW_FLUSH_EN (flush results whose exponent
// would reach zero or below, raising Underflow); otherwise such results become
// denormals with exponent 0 and Underflow stays 0.
module fp_add_normalize_stage
  import fpu_add_pkg::*;
(
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [RoundingSize-1:0] Adder1,
  input  logic [RoundingSize-1:0] Adder2,
  input  logic [ExponentSize-1:0] ExponentBase,
  input  logic                    EffOperation,
  input  logic                    ResultSign,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [RoundingSize-1:0] NormMantissa,
  output logic [ExponentSize-1:0] NormExponent,
  output logic                    OutSign,
  output logic                    Zero,
  output logic                    Overflow,
  output logic                    Underflow
);

  logic        s1_valid;
  logic        s2_valid;
  logic        s2_advance_c;
  s1_payload_t s1_q;
  s2_payload_t s2_q;
  s2_payload_t s2_c;

  logic [SumSize-1:0]      sum_c;
  logic [RoundingSize-1:0] low_c;
  logic [LzcSize-1:0]      lz_c;
  logic [ExpCalcSize-1:0]  base_c;
  logic [ExpCalcSize-1:0]  exp_c;
  logic [RoundingSize-1:0] mant_c;
`ifndef FP_UNDERFLOW_FLUSH_EN
  logic [ExponentSize-1:0] shift_c;
`endif

  // S2 moves when empty or drained; S1 moves when empty or S2 moves.
  assign s2_advance_c = !s2_valid | OutReady;
  assign InReady      = !s1_valid | s2_advance_c;

  assign sum_c = SumSize'(Adder1) + SumSize'(Adder2) + SumSize'(EffOperation);

  assign low_c  = s1_q.sum[RoundingSize-1:0];
  assign base_c = {1'b0, s1_q.exponent};

  LeadingZeroCounter #(.Width(RoundingSize)) u_lzc (
    .value (low_c),
    .count (lz_c)
  );

  // Normalize the registered sum and derive the adjusted exponent and flags.
  always_comb begin
    s2_c      = '0;
    exp_c     = '0;
    mant_c    = '0;
`ifndef FP_UNDERFLOW_FLUSH_EN
    shift_c   = '0;
`endif
    s2_c.sign = s1_q.sign;
    if (!s1_q.eff_sub) begin
      if (s1_q.sum[RoundingSize]) begin
        // Carry out: shift right one, folding the dropped bit into sticky.
        mant_c = {s1_q.sum[SumSize-1:2], s1_q.sum[1] | s1_q.sum[0]};
        exp_c  = base_c + ExpCalcSize'(1);
      end else begin
        mant_c = low_c;
        exp_c  = base_c;
      end
      if (s1_q.sum == '0) begin
        s2_c.zero = 1'b1;
      end else if (exp_c >= ExpCalcSize'(ExponentAllOnes)) begin
        s2_c.overflow = 1'b1;
        s2_c.exponent = ExponentAllOnes;
      end else begin
        s2_c.mantissa = mant_c;
        s2_c.exponent = exp_c[ExponentSize-1:0];
      end
    end else begin
      // Subtraction: the carry bit is discarded and the result left-justified.
      exp_c = base_c - ExpCalcSize'(lz_c);
      if (low_c == '0) begin
        s2_c.zero = 1'b1;
      end else if (ExpCalcSize'(lz_c) >= base_c) begin
`ifdef FP_UNDERFLOW_FLUSH_EN
        s2_c.underflow = 1'b1;
`else
        shift_c       = (s1_q.exponent == '0) ? '0 : s1_q.exponent - 1'b1;
        s2_c.mantissa = low_c << shift_c;
`endif
      end else if (exp_c >= ExpCalcSize'(ExponentAllOnes)) begin
        s2_c.overflow = 1'b1;
        s2_c.exponent = ExponentAllOnes;
      end else begin
        s2_c.mantissa = low_c << lz_c;
        s2_c.exponent = exp_c[ExponentSize-1:0];
      end
    end
  end

  // Add sub-stage register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (InReady) begin
      s1_valid <= InValid;
      if (InValid) s1_q <= '{sum: sum_c, exponent: ExponentBase,
                             eff_sub: EffOperation, sign: ResultSign};
    end
  end

  // Normalize sub-stage register; holds its contents while stalled.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_advance_c) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_q <= s2_c;
    end
  end

  assign OutValid     = s2_valid;
  assign NormMantissa = s2_q.mantissa;
  assign NormExponent = s2_q.exponent;
  assign OutSign      = s2_q.sign;
  assign Zero         = s2_q.zero;
  assign Overflow     = s2_q.overflow;
  assign Underflow    = s2_q.underflow;

endmodule
